// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared mode/state types and mode encodings for the sequential shifter
package shift_pkg;

    localparam logic [2:0] MODE_SHR  = 3'b000;
    localparam logic [2:0] MODE_SHRA = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_ROR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;

    typedef enum logic [2:0] {
        SHR  = MODE_SHR,
        SHRA = MODE_SHRA,
        SHL  = MODE_SHL,
        ROR  = MODE_ROR,
        ROL  = MODE_ROL
    } shift_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_e;

    // Encodings above ROL are reserved by the instruction decoder
    function automatic logic mode_is_legal(input logic [2:0] m);
        return m <= MODE_ROL;
    endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift/rotate of WIDTH bits by 0..STEP positions
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic [WIDTH-1:0] data,
    input  logic [AMT_W-1:0] amount,
    input  logic [2:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted
);

    logic [WIDTH-1:0] vacated;
    int               back;

    always_comb begin
        // a shift by WIDTH yields zero, so amount == 0 rotates cleanly
        back    = WIDTH - int'(amount);
        vacated = ~({WIDTH{1'b1}} >> amount);
        case (mode)
            SHR:     shifted = data >> amount;
            SHRA:    shifted = (data >> amount) | (vacated & {WIDTH{fill}});
            SHL:     shifted = data << amount;
            ROR:     shifted = (data >> amount) | (data << back);
            ROL:     shifted = (data << amount) | (data >> back);
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// rtl/seq_shifter.sv - multi-cycle shift/rotate unit with start/busy/done handshake
module seq_shifter
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               start,
    input  logic [2:0]         mode,
    input  logic [WIDTH-1:0]   operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   result,
    output logic               err
);

    // shamt never exceeds WIDTH-1, so a per-cycle step of WIDTH-1 covers STEP == WIDTH
    localparam int                 STEP_CAP = (STEP >= WIDTH) ? WIDTH - 1 : STEP;
    localparam logic [SHAMT_W-1:0] STEP_K   = STEP_CAP[SHAMT_W-1:0];

    shift_state_e       state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   stepped;
    logic [SHAMT_W-1:0] count;
    logic [SHAMT_W-1:0] k;
    logic [2:0]         mode_q;
    logic               fill_q;
    logic               mode_ok;

    assign k       = (count > STEP_K) ? STEP_K : count;
    assign mode_ok = mode_is_legal(mode);
    assign result  = work;

    shift_step #(
        .WIDTH (WIDTH),
        .AMT_W (SHAMT_W)
    ) u_step (
        .data    (work),
        .amount  (k),
        .mode    (mode_q),
        .fill    (fill_q),
        .shifted (stepped)
    );

    always_ff @(posedge clock) begin
        if (!clear) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            work   <= '0;
            count  <= '0;
            mode_q <= MODE_SHR;
            fill_q <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        work   <= operand;
                        mode_q <= mode;
                        fill_q <= operand[WIDTH-1];
                        count  <= shamt;
                        err    <= !mode_ok;
                        if (shamt == '0 || !mode_ok) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                SHIFT: begin
                    work  <= stepped;
                    count <= count - k;
                    if (count == k) begin
                        state <= DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// tb/tb_seq_shifter.sv - randomized and directed self-checking bench for seq_shifter
module tb_seq_shifter;

    localparam int W      = 32;
    localparam int STEP_A = 1;
    localparam int STEP_B = 4;

    logic          clock = 1'b0;
    logic          clear;
    logic          start, start_b;
    logic [2:0]    mode, mode_b;
    logic [W-1:0]  operand, operand_b;
    logic [4:0]    shamt, shamt_b;
    logic          busy, done, err, busy_b, done_b, err_b;
    logic [W-1:0]  result, result_b;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    seq_shifter #(.WIDTH(W), .STEP(STEP_A)) dut_a (
        .clock(clock), .clear(clear), .start(start), .mode(mode), .operand(operand),
        .shamt(shamt), .busy(busy), .done(done), .result(result), .err(err)
    );

    seq_shifter #(.WIDTH(W), .STEP(STEP_B)) dut_b (
        .clock(clock), .clear(clear), .start(start_b), .mode(mode_b), .operand(operand_b),
        .shamt(shamt_b), .busy(busy_b), .done(done_b), .result(result_b), .err(err_b)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [2:0] md, input int amt);
        case (md)
            3'd0: return v >> amt;
            3'd1: return 32'($signed(v) >>> amt);
            3'd2: return v << amt;
            3'd3: return (amt == 0) ? v : ((v >> amt) | (v << (32 - amt)));
            3'd4: return (amt == 0) ? v : ((v << amt) | (v >> (32 - amt)));
            default: return v;
        endcase
    endfunction

    // Model of dut_a: remembers the last accepted launch and its edge; every cycle's
    // outputs follow from elapsed cycles and the full shift arithmetic.
    int          ecnt = 0;
    bit          m_valid = 1'b0;
    int          m_acc, m_n, m_shamt;
    logic [31:0] m_op;
    logic [2:0]  m_mode;

    always @(posedge clock) begin
        ecnt <= ecnt + 1;
        if (!clear) begin
            m_valid <= 1'b0;
        end else if (start && !(m_valid && (ecnt - 1) < m_acc + m_n)) begin
            m_valid <= 1'b1;
            m_acc   <= ecnt;
            m_op    <= operand;
            m_mode  <= mode;
            m_shamt <= int'(shamt);
            m_n     <= (mode > 3'd4) ? 0 : (int'(shamt) + STEP_A - 1) / STEP_A;
        end
    end

    always @(negedge clock) begin : compare
        int          c, amt;
        logic [31:0] e_res;
        logic        e_busy, e_done, e_err;
        if (chk_en) begin
            c = ecnt - 1;
            if (!m_valid) begin
                e_busy = 1'b0; e_done = 1'b0; e_err = 1'b0; e_res = '0;
            end else begin
                e_busy = (c < m_acc + m_n);
                e_done = (c == m_acc + m_n);
                e_err  = (m_mode > 3'd4);
                amt    = STEP_A * (c - m_acc);
                if (amt > m_shamt) amt = m_shamt;
                e_res  = ref_shift(m_op, m_mode, amt);
            end
            check("cyc_busy", busy, e_busy);
            check("cyc_done", done, e_done);
            check("cyc_err", err, e_err);
            check("cyc_result", result, e_res);
        end
    end

    task automatic launch(input bit use_b, input logic [31:0] op, input logic [2:0] md, input logic [4:0] sh);
        if (use_b) begin
            operand_b = op; mode_b = md; shamt_b = sh; start_b = 1'b1;
        end else begin
            operand = op; mode = md; shamt = sh; start = 1'b1;
        end
    endtask

    // Called at a negedge; returns at the negedge where done is seen, lat=1 right after launch edge
    task automatic wait_done(input bit use_b, input string name, output int lat, output bit saw_busy);
        lat = 1;
        saw_busy = use_b ? busy_b : busy;
        while (!(use_b ? done_b : done) && lat < 100) begin
            @(negedge clock);
            lat++;
            saw_busy |= use_b ? busy_b : busy;
        end
        check({name, "_done_seen"}, use_b ? done_b : done, 1'b1);
    endtask

    task automatic run(input bit use_b, input string name, input logic [31:0] op, input logic [2:0] md,
                       input logic [4:0] sh, input logic [31:0] exp_res, input int exp_lat, input bit exp_err);
        int lat;
        bit sb;
        @(negedge clock);
        launch(use_b, op, md, sh);
        @(negedge clock);
        start = 1'b0; start_b = 1'b0;
        wait_done(use_b, name, lat, sb);
        check({name, "_result"}, use_b ? result_b : result, exp_res);
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_err"}, use_b ? err_b : err, exp_err);
        check({name, "_busy_seen"}, sb, exp_lat > 1);
    endtask

    initial begin
        int          lat, sh;
        bit          sb, saw_done;
        logic [31:0] op;
        logic [2:0]  md;
        clear = 1'b0; start = 1'b0; start_b = 1'b0;
        mode = '0; mode_b = '0; operand = '0; operand_b = '0; shamt = '0; shamt_b = '0;
        repeat (3) @(negedge clock);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_result", result, 32'h0);
        check("reset_err", err, 1'b0);
        check("model_shra", ref_shift(32'h8000_0010, 3'd1, 4), 32'hF800_0001);
        check("model_rol", ref_shift(32'h8000_0001, 3'd4, 1), 32'h0000_0003);
        chk_en = 1'b1;
        clear  = 1'b1;

        run(0, "shra", 32'h8000_0010, 3'd1, 5'd4, 32'hF800_0001, 5, 1'b0);
        run(0, "shr", 32'h8000_0010, 3'd0, 5'd4, 32'h0800_0001, 5, 1'b0);
        run(0, "rol", 32'h8000_0001, 3'd4, 5'd1, 32'h0000_0003, 2, 1'b0);
        run(0, "ror", 32'h0000_0003, 3'd3, 5'd1, 32'h8000_0001, 2, 1'b0);
        run(0, "shl0", 32'h1234_5678, 3'd2, 5'd0, 32'h1234_5678, 1, 1'b0);
        run(0, "illegal", 32'h1234_5678, 3'd7, 5'd9, 32'h1234_5678, 1, 1'b1);
        run(0, "max_shr", 32'hFFFF_FFFF, 3'd0, 5'd31, 32'h0000_0001, 32, 1'b0);
        run(1, "b_shl31", 32'h0000_0001, 3'd2, 5'd31, 32'h8000_0000, 9, 1'b0);
        run(1, "b_ror5", 32'h0000_0021, 3'd3, 5'd5, 32'h0800_0001, 3, 1'b0);

        // start during SHIFT must be ignored
        @(negedge clock);
        launch(0, 32'hFFFF_0000, 3'd0, 5'd20);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        launch(0, 32'h1234_5678, 3'd2, 5'd1);
        @(negedge clock);
        start = 1'b0;
        wait_done(0, "ignored", lat, sb);
        check("ignored_result", result, 32'h0000_0FFF);
        check("ignored_latency", lat, 21 - 4);

        // back-to-back: start in the DONE cycle
        @(negedge clock);
        launch(0, 32'h0000_0001, 3'd2, 5'd3);
        @(negedge clock);
        start = 1'b0;
        wait_done(0, "b2b_first", lat, sb);
        check("b2b_first_result", result, 32'h0000_0008);
        launch(0, 32'h0000_00F0, 3'd3, 5'd4);
        @(negedge clock);
        start = 1'b0;
        check("b2b_busy_rise", busy, 1'b1);
        check("b2b_done_drop", done, 1'b0);
        wait_done(0, "b2b_second", lat, sb);
        check("b2b_second_result", result, 32'h0000_000F);
        check("b2b_second_latency", lat, 5);

        // clear mid-SHIFT aborts without a done pulse
        @(negedge clock);
        launch(0, 32'hFFFF_FFFF, 3'd0, 5'd20);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        check("abort_busy", busy, 1'b0);
        check("abort_result", result, 32'h0);
        saw_done = 1'b0;
        repeat (25) begin
            @(negedge clock);
            saw_done |= done;
        end
        check("abort_no_done", saw_done, 1'b0);

        // clear together with start stays idle
        clear = 1'b0;
        launch(0, 32'h0000_0005, 3'd2, 5'd2);
        @(negedge clock);
        clear = 1'b1; start = 1'b0;
        check("clr_start_busy", busy, 1'b0);
        check("clr_start_done", done, 1'b0);
        check("clr_start_result", result, 32'h0);
        @(negedge clock);
        check("clr_start_idle", done | busy, 1'b0);

        // randomized traffic on dut_a, checked every cycle by the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            start   = ($urandom_range(0, 3) == 0);
            operand = $urandom;
            mode    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            shamt   = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 4)) : 5'($urandom);
            clear   = ($urandom_range(0, 149) != 0);
        end
        @(negedge clock);
        start = 1'b0; clear = 1'b1;

        // randomized transactions on the STEP=4 instance
        for (int i = 0; i < 40; i++) begin
            op = $urandom;
            md = ($urandom_range(0, 7) == 0) ? 3'd6 : 3'($urandom_range(0, 4));
            sh = $urandom_range(0, 31);
            run(1, "b_rand", op, md, 5'(sh), ref_shift(op, md, sh),
                (md > 3'd4) ? 1 : (sh + STEP_B - 1) / STEP_B + 1, md > 3'd4);
        end

        repeat (2) @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
